// File: rtl/reg_write_arbiter.sv
// Four-requester register-write arbiter feeding a demux; one write in flight at a time.
// Define ARB_ROUND_ROBIN_EN for rotating priority; the default build is fixed priority (0 highest).
module reg_write_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] data3,
    input  logic              dst_stall,
    output logic [3:0]        ack,
    output logic [1:0]        dmx_sel,
    output logic [DATA_W-1:0] dmx_data,
    output logic              dmx_wr,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        last_gnt;
    logic [1:0]        scan_base;
    logic [1:0]        scan_idx;
    logic [1:0]        winner;
    logic              found;
    logic [DATA_W-1:0] win_data;

    // The scan starts just after scan_base; pinning the base to 3 turns it into
    // fixed priority with requester 0 first, while last_gnt is still tracked.
`ifdef ARB_ROUND_ROBIN_EN
    assign scan_base = last_gnt;
`else
    assign scan_base = last_gnt | 2'b11;
`endif

    always_comb begin
        winner   = 2'd0;
        found    = 1'b0;
        scan_idx = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = scan_base + 2'(k);
            if (!found && req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = data0;
        case (winner)
            2'd0:    win_data = data0;
            2'd1:    win_data = data1;
            2'd2:    win_data = data2;
            default: win_data = data3;
        endcase
    end

    // A write that sees reset in its final cycle is aborted, so ack is masked by rst.
    always_comb begin
        state_nxt = state;
        ack       = 4'b0000;
        dmx_wr    = 1'b0;
        case (state)
            IDLE: begin
                if (req != 4'b0000) state_nxt = WRITE;
            end
            WRITE: begin
                dmx_wr = 1'b1;
                if (!dst_stall) begin
                    state_nxt = IDLE;
                    if (!rst) ack = 4'b0001 << dmx_sel;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dmx_sel  <= 2'd0;
            dmx_data <= '0;
            last_gnt <= 2'd3;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req != 4'b0000) begin
                dmx_sel  <= winner;
                dmx_data <= win_data;
                last_gnt <= winner;
            end
        end
    end

    assign busy = (state == WRITE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: scenario tasks with an expected-grant queue.
// Expected grant order follows ARB_ROUND_ROBIN_EN the same way the design does.
module tb_reg_write_arbiter;

  localparam int DW = 8;
  localparam int EW = 4 + 2 + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [DW-1:0] data0, data1, data2, data3;
  logic          dst_stall;
  logic [3:0]    ack;
  logic [1:0]    dmx_sel;
  logic [DW-1:0] dmx_data;
  logic          dmx_wr;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_v;
  logic [EW-1:0] got_v;

  reg_write_arbiter #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .dst_stall(dst_stall), .ack(ack), .dmx_sel(dmx_sel),
    .dmx_data(dmx_data), .dmx_wr(dmx_wr), .busy(busy)
  );

  // clock/reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic pulse_reset();
    @(posedge clk); #1;
    req = 4'b0000; dst_stall = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; dst_stall = 1'b0;
    data0 = '0; data1 = '0; data2 = '0; data3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (dmx_wr !== 1'b0) begin failures++; $display("FAIL reset_dmx_wr got=%b exp=0", dmx_wr); end
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (dmx_sel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", dmx_sel); end
    checks++; if (dmx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", dmx_data); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    req = 4'b0100; data2 = 8'hA5;
    exp_q.push_back({4'b0100, 2'd2, 8'hA5});
    @(negedge clk);
    checks++; if ({busy, dmx_wr, ack} !== 6'b0) begin failures++; $display("FAIL single_pre got=%b exp=000000", {busy, dmx_wr, ack}); end
    @(negedge clk);
    exp_v = exp_q.pop_front();
    got_v = {ack, dmx_sel, dmx_data};
    checks++; if (got_v !== exp_v) begin failures++; $display("FAIL single_grant got=%h exp=%h", got_v, exp_v); end
    checks++; if ({dmx_wr, busy} !== 2'b11) begin failures++; $display("FAIL single_wr got=%b exp=11", {dmx_wr, busy}); end
    @(posedge clk); #1;
    req = 4'b0000;
    @(negedge clk);
    checks++; if ({busy, dmx_wr, ack} !== 6'b0) begin failures++; $display("FAIL single_post got=%b exp=000000", {busy, dmx_wr, ack}); end
    checks++; if ({dmx_sel, dmx_data} !== {2'd2, 8'hA5}) begin failures++; $display("FAIL single_hold got=%h exp=%h", {dmx_sel, dmx_data}, {2'd2, 8'hA5}); end
  endtask

  task automatic test_stall();
    @(posedge clk); #1;
    req = 4'b0001; data0 = 8'h3C; dst_stall = 1'b1;
    exp_q.push_back({4'b0001, 2'd0, 8'h3C});
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got_v = {ack, dmx_sel, dmx_data};
      checks++; if (got_v !== {4'b0000, 2'd0, 8'h3C} || dmx_wr !== 1'b1 || busy !== 1'b1) begin
        failures++; $display("FAIL stall_hold cyc%0d got=%h wr=%b busy=%b exp=%h wr=1 busy=1", i, got_v, dmx_wr, busy, {4'b0000, 2'd0, 8'h3C});
      end
      @(posedge clk);
    end
    #1 dst_stall = 1'b0;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    got_v = {ack, dmx_sel, dmx_data};
    checks++; if (got_v !== exp_v || dmx_wr !== 1'b1) begin failures++; $display("FAIL stall_release got=%h wr=%b exp=%h wr=1", got_v, dmx_wr, exp_v); end
    @(posedge clk); #1;
    req = 4'b0000;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_done busy got=%b exp=0", busy); end
  endtask

  task automatic test_late_request();
    @(posedge clk); #1;
    req = 4'b0001; data0 = 8'h5A; data3 = 8'hC3; dst_stall = 1'b1;
    exp_q.push_back({4'b0001, 2'd0, 8'h5A});
    exp_q.push_back({4'b1000, 2'd3, 8'hC3});
    @(posedge clk); #1;
    req = 4'b1001;
    @(negedge clk);
    got_v = {ack, dmx_sel, dmx_data};
    checks++; if (got_v !== {4'b0000, 2'd0, 8'h5A}) begin failures++; $display("FAIL late_inflight got=%h exp=%h", got_v, {4'b0000, 2'd0, 8'h5A}); end
    @(posedge clk); #1;
    dst_stall = 1'b0;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    got_v = {ack, dmx_sel, dmx_data};
    checks++; if (got_v !== exp_v) begin failures++; $display("FAIL late_first got=%h exp=%h", got_v, exp_v); end
    @(posedge clk); #1;
    req = 4'b1000;
    @(negedge clk);
    checks++; if ({busy, ack} !== 5'b0) begin failures++; $display("FAIL late_idle got=%b exp=00000", {busy, ack}); end
    @(negedge clk);
    exp_v = exp_q.pop_front();
    got_v = {ack, dmx_sel, dmx_data};
    checks++; if (got_v !== exp_v) begin failures++; $display("FAIL late_second got=%h exp=%h", got_v, exp_v); end
    @(posedge clk); #1;
    req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    req = 4'b0010; data1 = 8'h77; dst_stall = 1'b0;
    exp_q.push_back({4'b0010, 2'd1, 8'h77});
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL rstmid_noack got=%b exp=0000", ack); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    got_v = {ack, dmx_sel, dmx_data};
    checks++; if (got_v !== '0 || dmx_wr !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rstmid_cleared got=%h wr=%b busy=%b exp=0 wr=0 busy=0", got_v, dmx_wr, busy);
    end
    @(negedge clk);
    exp_v = exp_q.pop_front();
    got_v = {ack, dmx_sel, dmx_data};
    checks++; if (got_v !== exp_v) begin failures++; $display("FAIL rstmid_regrant got=%h exp=%h", got_v, exp_v); end
    @(posedge clk); #1;
    req = 4'b0000;
  endtask

  // All four request at once and each drops after its ack: order 0..3 in both modes, 2 cycles apart.
  task automatic test_back_to_back();
    logic [3:0] drop;
    int prev;
    pulse_reset();
    prev = -1;
    data0 = 8'h11; data1 = 8'h22; data2 = 8'h33; data3 = 8'h44;
    req = 4'b1111;
    exp_q.push_back({4'b0001, 2'd0, 8'h11});
    exp_q.push_back({4'b0010, 2'd1, 8'h22});
    exp_q.push_back({4'b0100, 2'd2, 8'h33});
    exp_q.push_back({4'b1000, 2'd3, 8'h44});
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      drop = 4'b0000;
      if (ack !== 4'b0000) begin
        exp_v = exp_q.pop_front();
        got_v = {ack, dmx_sel, dmx_data};
        checks++; if (got_v !== exp_v) begin failures++; $display("FAIL b2b_grant got=%h exp=%h", got_v, exp_v); end
        if (prev >= 0) begin
          checks++; if (cyc - prev != 2) begin failures++; $display("FAIL b2b_spacing got=%0d exp=2", cyc - prev); end
        end
        prev = cyc;
        drop = ack;
      end
      @(posedge clk); #1;
      req = req & ~drop;
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL b2b_timeout got=%0d pending exp=0", exp_q.size());
      exp_q.delete();
    end
    req = 4'b0000;
  endtask

  // Requester 1 keeps requesting for three grants; requester 3 drops after its one ack.
  task automatic test_priority();
    int n1;
    logic [3:0] drop;
    pulse_reset();
    n1 = 0;
    data1 = 8'h5C; data3 = 8'hE1;
    req = 4'b1010;
`ifdef ARB_ROUND_ROBIN_EN
    exp_q.push_back({4'b0010, 2'd1, 8'h5C});
    exp_q.push_back({4'b1000, 2'd3, 8'hE1});
    exp_q.push_back({4'b0010, 2'd1, 8'h5C});
    exp_q.push_back({4'b0010, 2'd1, 8'h5C});
`else
    exp_q.push_back({4'b0010, 2'd1, 8'h5C});
    exp_q.push_back({4'b0010, 2'd1, 8'h5C});
    exp_q.push_back({4'b0010, 2'd1, 8'h5C});
    exp_q.push_back({4'b1000, 2'd3, 8'hE1});
`endif
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      drop = 4'b0000;
      if (ack !== 4'b0000) begin
        exp_v = exp_q.pop_front();
        got_v = {ack, dmx_sel, dmx_data};
        checks++; if (got_v !== exp_v) begin failures++; $display("FAIL prio_grant got=%h exp=%h", got_v, exp_v); end
        if (ack[1] === 1'b1) begin
          n1++;
          if (n1 == 3) drop[1] = 1'b1;
        end
        if (ack[3] === 1'b1) drop[3] = 1'b1;
      end
      @(posedge clk); #1;
      req = req & ~drop;
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL prio_timeout got=%0d pending exp=0", exp_q.size());
      exp_q.delete();
    end
    req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_late_request();
    test_reset_mid();
    test_back_to_back();
    test_priority();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter: DATA_W, default 8, width of each requester's data word and of the demux data path.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  4  per-requester write request; bit i belongs to requester i; held high until its ack.
REQ-005 Port: data0..data3  input  DATA_W each  write data of requester 0..3; stable while its req is high.
REQ-006 Port: dst_stall  input  1  downstream not ready; holds the current write.
REQ-007 Port: ack  output  4  one-hot, one-cycle pulse; the granted requester's write has been accepted.
REQ-008 Port: dmx_sel  output  2  demux select; index of the granted requester.
REQ-009 Port: dmx_data  output  DATA_W  latched data of the granted requester, drives the demux input.
REQ-010 Port: dmx_wr  output  1  write strobe qualifying dmx_sel/dmx_data.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE and WRITE only.
REQ-013 IDLE: if req != 0, arbitration SHALL pick a winner, register dmx_sel = winner and dmx_data = data[winner], and enter WRITE next cycle; if req == 0, remain IDLE.
REQ-014 WRITE: dmx_wr SHALL be 1, with dmx_sel and dmx_data held constant for the whole state.
REQ-015 WRITE with dst_stall = 0: ack[dmx_sel] SHALL pulse high combinationally in that cycle, and the FSM SHALL return to IDLE.
REQ-016 WRITE with dst_stall = 1: ack SHALL stay 0, and the FSM SHALL stay in WRITE with all outputs unchanged.
REQ-017 Minimum latency from req rising in IDLE to ack SHALL be 1 cycle (req sampled at edge N, ack during cycle N+1); peak throughput SHALL be one write per 2 cycles.
REQ-018 Outside WRITE: dmx_wr = 0, ack = 0, and dmx_sel/dmx_data SHALL hold their last values.
REQ-019 Requests arriving or dropping during WRITE SHALL NOT alter the in-flight transfer; they are evaluated at the next IDLE.
REQ-020 A requester dropping req without receiving ack SHALL simply be excluded from the next arbitration; no error is flagged.
REQ-021 At most one ack bit SHALL be high in any cycle.
REQ-022 The last-winner pointer last_gnt (2 bits) SHALL update to the winner on the IDLE->WRITE transition only.

Reset
REQ-023 While rst = 1 at a rising edge: state <= IDLE, dmx_sel <= 0, dmx_data <= 0, last_gnt <= 3.
REQ-024 Consequently, in the cycle after reset: dmx_wr = 0, ack = 0, busy = 0.
REQ-025 Reset asserted during WRITE SHALL abort the transfer without an ack; the requester keeps req high and is re-arbitrated after reset.

Configuration
REQ-026 Macro ARB_ROUND_ROBIN_EN defined: the winner SHALL be the first requesting index scanning last_gnt+1, +2, +3, +4 (mod 4).
REQ-027 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, with requester 0 highest and 3 lowest; last_gnt is still maintained but unused.

Verification
REQ-028 Single: reset, req=0100, data2=8'hA5, stall=0 -> next cycle dmx_wr=1, dmx_sel=2, dmx_data=A5, ack=0100; cycle after that busy=0.
REQ-029 Stall: req=0001, data0=8'h3C, stall=1 for 3 WRITE cycles -> dmx_wr=1 with outputs stable for 4 cycles, ack=0001 only in the 4th (stall=0).
REQ-030 Round robin (ARB_ROUND_ROBIN_EN): req=1111 held, each requester drops its req after its ack -> ack order 0001, 0010, 0100, 1000, each 2 cycles apart.
REQ-031 Fixed priority (macro off): req=1010 held; requester 1 re-requests immediately after its ack -> requester 1 wins every arbitration while it requests; requester 3 is granted only once req[1]=0.
REQ-032 Reset mid-transfer: req=0010, data1=8'h77, rst=1 in the WRITE cycle -> no ack, next cycle dmx_wr=0, dmx_sel=0, dmx_data=0; after rst releases, ack=0010 two cycles later.
REQ-033 Late request: req=0001 granted, req[3] rises during WRITE -> transfer 0 completes unchanged; requester 3 is granted in the following IDLE.
